// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake and byte-laned data-RAM bus of the data-memory port.
// master = the access controller, slave = pipeline stage plus RAM.
interface mem_access_ctrl_if #(parameter int ADDR_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              ram_en;
    logic              ram_we;
    logic [3:0]        ram_sel;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              exc_adel;
    logic              exc_ades;
    logic [ADDR_W-1:0] exc_badvaddr;
    logic              stall;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_rdata,
        output req_ready, ram_en, ram_we, ram_sel, ram_addr, ram_wdata,
        output resp_valid, resp_rdata, exc_adel, exc_ades, exc_badvaddr, stall
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_rdata,
        input  req_ready, ram_en, ram_we, ram_sel, ram_addr, ram_wdata,
        input  resp_valid, resp_rdata, exc_adel, exc_ades, exc_badvaddr, stall
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Data-memory initiator: one load/store at a time on a big-endian byte-laned RAM,
// with alignment checking and sign/zero extension of load data.
module mem_access_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state;
    logic              we_q;
    logic              uns_q;
    logic [1:0]        size_q;
    logic [1:0]        off_q;
    logic              ready_q;
    logic              en_q;
    logic              wr_q;
    logic [3:0]        sel_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [31:0]       ram_wdata_q;
    logic              resp_valid_q;
    logic [31:0]       resp_rdata_q;
    logic              adel_q;
    logic              ades_q;
    logic [ADDR_W-1:0] badv_q;

    logic              misaligned;
    logic [3:0]        sel_next;
    logic [31:0]       lane_wdata;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [31:0]       load_ext;

    always_comb begin
        misaligned = 1'b0;
        sel_next   = 4'b1111;
        lane_wdata = bus.req_wdata;
        case (bus.req_size)
            2'd0: begin
                sel_next   = 4'b1000 >> bus.req_addr[1:0];
                lane_wdata = {4{bus.req_wdata[7:0]}};
            end
            2'd1: begin
                misaligned = bus.req_addr[0];
                sel_next   = bus.req_addr[1] ? 4'b0011 : 4'b1100;
                lane_wdata = {2{bus.req_wdata[15:0]}};
            end
            default: misaligned = |bus.req_addr[1:0];
        endcase
    end

    // Big-endian lane pick: byte offset 0 lives in bits [31:24].
    always_comb begin
        case (off_q)
            2'd0:    byte_v = bus.ram_rdata[31:24];
            2'd1:    byte_v = bus.ram_rdata[23:16];
            2'd2:    byte_v = bus.ram_rdata[15:8];
            default: byte_v = bus.ram_rdata[7:0];
        endcase
        half_v = off_q[1] ? bus.ram_rdata[15:0] : bus.ram_rdata[31:16];
        case (size_q)
            2'd0:    load_ext = {{24{byte_v[7] & ~uns_q}}, byte_v};
            2'd1:    load_ext = {{16{half_v[15] & ~uns_q}}, half_v};
            default: load_ext = bus.ram_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            size_q       <= 2'd0;
            off_q        <= 2'd0;
            ready_q      <= 1'b1;
            en_q         <= 1'b0;
            wr_q         <= 1'b0;
            sel_q        <= 4'b0000;
            ram_addr_q   <= '0;
            ram_wdata_q  <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            adel_q       <= 1'b0;
            ades_q       <= 1'b0;
            badv_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        uns_q   <= bus.req_unsigned;
                        size_q  <= bus.req_size;
                        off_q   <= bus.req_addr[1:0];
                        ready_q <= 1'b0;
                        if (misaligned) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= 32'h0;
                            adel_q       <= ~bus.req_we;
                            ades_q       <= bus.req_we;
                            badv_q       <= bus.req_addr;
                        end else begin
                            state       <= ACCESS;
                            en_q        <= 1'b1;
                            wr_q        <= bus.req_we;
                            sel_q       <= sel_next;
                            ram_addr_q  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                            ram_wdata_q <= lane_wdata;
                        end
                    end
                end
                ACCESS: begin
                    state        <= RESP;
                    en_q         <= 1'b0;
                    wr_q         <= 1'b0;
                    sel_q        <= 4'b0000;
                    ram_addr_q   <= '0;
                    ram_wdata_q  <= 32'h0;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= we_q ? 32'h0 : load_ext;
                    adel_q       <= 1'b0;
                    ades_q       <= 1'b0;
                    badv_q       <= '0;
                end
                RESP: begin
                    state        <= IDLE;
                    resp_valid_q <= 1'b0;
                    ready_q      <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are masked by rst so an access cut short by reset never writes.
    assign bus.ram_en       = en_q & ~rst;
    assign bus.ram_we       = wr_q & ~rst;
    assign bus.ram_sel      = sel_q & {4{~rst}};
    assign bus.ram_addr     = ram_addr_q;
    assign bus.ram_wdata    = ram_wdata_q;
    assign bus.req_ready    = ready_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_rdata   = resp_rdata_q;
    assign bus.exc_adel     = adel_q;
    assign bus.exc_ades     = ades_q;
    assign bus.exc_badvaddr = badv_q;
    assign bus.stall        = bus.req_valid & ~rst & (state != RESP);
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed and random loads/stores checked every cycle
// against a byte-addressed memory and an accept/latency timeline model.
module tb_mem_access_ctrl;
    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   load_mem = 1'b1;

    mem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    mem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [31:0] init_words [0:255];
    logic [31:0] ram        [0:255];
    logic [7:0]  gmem       [0:1023];

    logic        snap_en;
    logic [3:0]  snap_sel;
    logic [31:0] snap_addr;
    logic [31:0] snap_wdata;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic reportTimeout(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: timed out waiting on the DUT (cycle %0d)", name, cyc);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Data RAM as the DUT sees it: combinational read, byte-masked write.
    assign bus.ram_rdata = ram[bus.ram_addr[9:2]];

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_words[i];
        end else if (bus.ram_en === 1'b1 && bus.ram_we === 1'b1) begin
            ram[bus.ram_addr[9:2]] <= merge(ram[bus.ram_addr[9:2]], bus.ram_wdata, bus.ram_sel);
        end
    end

    function automatic int nbytesOf(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit isAligned(input logic [1:0] off, input int n);
        return (int'(off) % n) == 0;
    endfunction

    function automatic logic [3:0] laneSel(input logic [1:0] off, input int n);
        logic [3:0] s;
        s = 4'b0000;
        for (int k = 0; k < n; k++)
            if (int'(off) + k <= 3) s[3 - (int'(off) + k)] = 1'b1;
        return s;
    endfunction

    // Lane b carries memory offset 3-b; an n-byte store repeats every n offsets.
    function automatic logic [31:0] laneData(input logic [31:0] wdata, input int n);
        logic [31:0] v;
        for (int b = 0; b < 4; b++)
            v[8*b +: 8] = wdata[8*(n - 1 - ((3 - b) % n)) +: 8];
        return v;
    endfunction

    function automatic logic [31:0] loadValue(input logic [9:0] a, input int n, input bit uns);
        logic [31:0] v;
        v = 32'h0;
        for (int k = 0; k < n; k++) v = (v << 8) | {24'h0, gmem[int'(a) + k]};
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    bit          busy = 1'b0;
    int          age  = 0;
    int          lat  = 0;
    bit          m_we = 1'b0;
    bit          m_al = 1'b0;
    int          m_n  = 4;
    logic [9:0]  m_addr  = '0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_sel   = '0;
    logic [31:0] m_lanes = '0;
    logic [31:0] p_rdata = '0;
    logic [31:0] last_rdata = '0;
    bit          last_adel  = 1'b0;
    bit          last_ades  = 1'b0;
    logic [31:0] last_badv  = '0;

    // Reference: a request is taken whenever nothing is outstanding; it answers
    // 2 cycles later (aligned) or 1 cycle later (misaligned), stores land at the first.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load_mem)
            for (int i = 0; i < 1024; i++) gmem[i] <= init_words[i/4][8*(3 - i%4) +: 8];
        if (rst) begin
            busy       <= 1'b0;
            age        <= 0;
            last_rdata <= '0;
            last_adel  <= 1'b0;
            last_ades  <= 1'b0;
            last_badv  <= '0;
        end else if (!busy) begin
            if (bus.req_valid === 1'b1) begin
                busy    <= 1'b1;
                age     <= 1;
                m_we    <= bus.req_we;
                m_al    <= isAligned(bus.req_addr[1:0], nbytesOf(bus.req_size));
                m_n     <= nbytesOf(bus.req_size);
                m_addr  <= bus.req_addr[9:0];
                m_wdata <= bus.req_wdata;
                m_sel   <= laneSel(bus.req_addr[1:0], nbytesOf(bus.req_size));
                m_lanes <= laneData(bus.req_wdata, nbytesOf(bus.req_size));
                if (isAligned(bus.req_addr[1:0], nbytesOf(bus.req_size))) begin
                    lat     <= 2;
                    p_rdata <= bus.req_we ? 32'h0
                             : loadValue(bus.req_addr[9:0], nbytesOf(bus.req_size), bus.req_unsigned);
                end else begin
                    lat        <= 1;
                    last_rdata <= 32'h0;
                    last_adel  <= ~bus.req_we;
                    last_ades  <= bus.req_we;
                    last_badv  <= bus.req_addr;
                end
            end
        end else begin
            if (age >= lat) busy <= 1'b0;
            else            age  <= age + 1;
            if (age == 1 && m_al) begin
                last_rdata <= p_rdata;
                last_adel  <= 1'b0;
                last_ades  <= 1'b0;
                last_badv  <= '0;
                if (m_we)
                    for (int k = 0; k < 4; k++)
                        if (k < m_n) gmem[int'(m_addr) + k] <= m_wdata[8*(m_n - 1 - k) +: 8];
            end
        end
    end

    always begin : compare
        bit in_acc;
        bit in_resp;
        @(negedge clk);
        #2;
        in_acc  = busy && m_al && (age == 1);
        in_resp = busy && (age == lat);
        if (rst) begin
            checkOutput("ram_en_in_reset", bus.ram_en, 32'h0);
            checkOutput("ram_we_in_reset", bus.ram_we, 32'h0);
            checkOutput("ram_sel_in_reset", bus.ram_sel, 32'h0);
            checkOutput("stall_in_reset", bus.stall, 32'h0);
        end else begin
            checkOutput("req_ready", bus.req_ready, !busy);
            checkOutput("ram_en", bus.ram_en, in_acc);
            checkOutput("ram_we", bus.ram_we, in_acc && m_we);
            checkOutput("ram_sel", bus.ram_sel, in_acc ? m_sel : 4'b0000);
            checkOutput("ram_addr", bus.ram_addr, in_acc ? {22'h0, m_addr[9:2], 2'b00} : 32'h0);
            checkOutput("ram_wdata", bus.ram_wdata, in_acc ? m_lanes : 32'h0);
            checkOutput("resp_valid", bus.resp_valid, in_resp);
            checkOutput("resp_rdata", bus.resp_rdata, last_rdata);
            checkOutput("exc_adel", bus.exc_adel, last_adel);
            checkOutput("exc_ades", bus.exc_ades, last_ades);
            checkOutput("exc_badvaddr", bus.exc_badvaddr, last_badv);
            checkOutput("stall", bus.stall, (bus.req_valid === 1'b1) && !in_resp);
        end
    end

    task automatic applyStimulus(input bit we, input logic [1:0] size, input bit uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input bit hold, output int acc_cyc);
        int guard;
        @(negedge clk);
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_valid    = 1'b1;
        guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) reportTimeout("accept_wait");
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic waitResp(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                snap_en    = bus.ram_en;
                snap_sel   = bus.ram_sel;
                snap_addr  = bus.ram_addr;
                snap_wdata = bus.ram_wdata;
            end
        end while (bus.resp_valid !== 1'b1 && n < 8);
        if (bus.resp_valid !== 1'b1) reportTimeout("resp_wait");
    endtask

    task automatic doReq(input string name, input bit we, input logic [1:0] size, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat,
                         input logic [31:0] exp_rdata, input bit exp_adel, input bit exp_ades);
        int acc;
        int n;
        applyStimulus(we, size, uns, addr, wdata, 1'b0, acc);
        waitResp(n);
        checkOutput({name, "_latency"}, 32'(n), 32'(exp_lat));
        checkOutput({name, "_rdata"}, bus.resp_rdata, exp_rdata);
        checkOutput({name, "_adel"}, bus.exc_adel, exp_adel);
        checkOutput({name, "_ades"}, bus.exc_ades, exp_ades);
    endtask

    initial begin : watchdog
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int t0, t1, t2, t3, n;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        for (int i = 0; i < 256; i++) init_words[i] = $urandom();
        init_words[4]  = 32'h8000_00F1;
        init_words[8]  = 32'hCAFE_F00D;
        init_words[12] = 32'h5566_7788;
        init_words[16] = 32'h1122_3344;
        repeat (3) @(negedge clk);
        load_mem = 1'b0;
        rst      = 1'b0;
        #2;
        checkOutput("reset_req_ready", bus.req_ready, 32'h1);
        checkOutput("reset_resp_valid", bus.resp_valid, 32'h0);
        checkOutput("reset_resp_rdata", bus.resp_rdata, 32'h0);

        doReq("lw_10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 2, 32'h8000_00F1, 1'b0, 1'b0);
        doReq("lb_10", 1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 2, 32'hFFFF_FF80, 1'b0, 1'b0);
        doReq("lbu_13", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 2, 32'h0000_00F1, 1'b0, 1'b0);

        doReq("sb_21", 1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_00AB, 2, 32'h0, 1'b0, 1'b0);
        checkOutput("sb_21_sel", snap_sel, 32'h4);
        checkOutput("sb_21_wdata", snap_wdata, 32'hABAB_ABAB);
        checkOutput("sb_21_addr", snap_addr, 32'h20);
        doReq("lw_20", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 2, 32'hCAAB_F00D, 1'b0, 1'b0);

        doReq("sh_32", 1'b1, 2'd1, 1'b0, 32'h32, 32'h0000_1234, 2, 32'h0, 1'b0, 1'b0);
        checkOutput("sh_32_sel", snap_sel, 32'h3);
        checkOutput("sh_32_wdata", snap_wdata, 32'h1234_1234);
        doReq("lw_30", 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 2, 32'h5566_1234, 1'b0, 1'b0);
        doReq("sh_32b", 1'b1, 2'd1, 1'b0, 32'h32, 32'h0000_8001, 2, 32'h0, 1'b0, 1'b0);
        doReq("lh_32", 1'b0, 2'd1, 1'b0, 32'h32, 32'h0, 2, 32'hFFFF_8001, 1'b0, 1'b0);
        doReq("lhu_32", 1'b0, 2'd1, 1'b1, 32'h32, 32'h0, 2, 32'h0000_8001, 1'b0, 1'b0);

        doReq("lw_102", 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 1, 32'h0, 1'b1, 1'b0);
        checkOutput("lw_102_no_ram_en", snap_en, 32'h0);
        checkOutput("lw_102_badvaddr", bus.exc_badvaddr, 32'h102);
        doReq("sh_5", 1'b1, 2'd1, 1'b0, 32'h5, 32'h0, 1, 32'h0, 1'b0, 1'b1);
        checkOutput("sh_5_badvaddr", bus.exc_badvaddr, 32'h5);

        // Requester keeps req_valid high across four requests.
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, t0);
        applyStimulus(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b1, t1);
        applyStimulus(1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 1'b1, t2);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, t3);
        checkOutput("b2b_spacing_0", 32'(t1 - t0), 32'd3);
        checkOutput("b2b_spacing_1", 32'(t2 - t1), 32'd3);
        checkOutput("b2b_spacing_misaligned", 32'(t3 - t2), 32'd2);
        waitResp(n);

        applyStimulus(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEAD_BEEF, 1'b0, t0);
        @(negedge clk);
        rst = 1'b1;
        #2;
        checkOutput("rst_access_ram_we", bus.ram_we, 32'h0);
        checkOutput("rst_access_ram_en", bus.ram_en, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_after_resp_valid", bus.resp_valid, 32'h0);
        @(negedge clk);
        checkOutput("rst_after_req_ready", bus.req_ready, 32'h1);
        checkOutput("rst_after_no_resp", bus.resp_valid, 32'h0);
        doReq("lw_40", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 2, 32'h1122_3344, 1'b0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            int gap;
            bit hold;
            gap  = $urandom_range(0, 2);
            hold = ($urandom_range(0, 2) == 0);
            if (gap > 0) begin
                bus.req_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            applyStimulus($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                          32'($urandom_range(0, 1023)), $urandom(), hold, t0);
        end
        bus.req_valid = 1'b0;
        repeat (6) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
